jk_bank_sequencer: RTL and testbench
====================================

JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, is the number of JK flip-flops in the controlled bank.
REQ-002 Parameter SETTLE_CYCLES, default 1 (legal 1-15), is the number of idle cycles between drive and check.
REQ-003 input_clock1_c_1  in  1  the single clock; all state updates on its rising edge.
REQ-004 input_reset_n  in  1  reset, synchronous, active-low.
REQ-005 req  in  2  per-requester command request, bit r = requester r.
REQ-006 op0, op1  in  3 each  command: 000 hold, 001 set, 010 reset, 011 toggle, 100 preset-all, 101 clear-all; 110/111 illegal.
REQ-007 mask0, mask1  in  WIDTH each  bit select for set/reset/toggle/hold.
REQ-008 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-009 err  out  1  one-cycle error pulse, coincident with ack.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 jk_j, jk_k  out  WIDTH each  J and K drive to the bank.
REQ-012 jk_preset_n, jk_clear_n  out  1 each  active-low preset/clear drive to the bank.
REQ-013 q_in, qbar_in  in  WIDTH each  Q and Qbar read back from the bank.

Function
REQ-014 FSM states IDLE, DRIVE, SETTLE, CHECK; encoding is free.
REQ-015 IDLE: with any req bit high, grant one requester, latch its op/mask, snapshot q_in, go to DRIVE; otherwise stay.
REQ-016 Arbitration is 2-way round robin: on simultaneous requests the pointer winner is granted, and the pointer moves to the other requester after every grant.
REQ-017 DRIVE lasts exactly 1 cycle: set -> jk_j=mask; reset -> jk_k=mask; toggle -> jk_j=jk_k=mask; hold -> both 0; preset-all -> jk_preset_n=0; clear-all -> jk_clear_n=0.
REQ-018 Outside DRIVE: jk_j=jk_k=0 and jk_preset_n=jk_clear_n=1.
REQ-019 SETTLE lasts SETTLE_CYCLES cycles; the counter reloads on every DRIVE entry.
REQ-020 CHECK lasts 1 cycle, asserts ack[granted], then returns to IDLE.
REQ-021 Latency from req sampled high in IDLE to ack is 2+SETTLE_CYCLES cycles (3 at default).
REQ-022 Requester holds req and op/mask stable until ack; req still high in the cycle after ack is a new request.
REQ-023 err in CHECK if any bit has q_in==qbar_in.
REQ-024 err in CHECK if masked Q mismatches expectation: set -> all 1; reset -> all 0; toggle -> inverted snapshot; hold -> equal to snapshot.
REQ-025 err in CHECK if preset-all gives q_in not all 1, or clear-all gives q_in not all 0.
REQ-026 Illegal op: skip DRIVE activity (outputs stay safe), still traverse all states, assert err with ack.
REQ-027 mask=0 for set/reset/toggle/hold is legal: no drive, err from REQ-023 only.

Reset
REQ-028 With input_reset_n low at a clock edge: state IDLE, RR pointer to requester 0, ack=0, err=0, busy=0, jk_j=jk_k=0, jk_preset_n=jk_clear_n=1, counter and latches 0.
REQ-029 Reset mid-operation aborts the command with no ack, no err, and no further bank drive.

Structure
REQ-030 Shared package jk_ctrl_pkg holds the op code enum, FSM state enum and the WIDTH default.
REQ-031 The round-robin grant logic is one sub-module, jk_rr_arbiter (2 requesters, pointer register, one-hot grant).

Verification
REQ-032 Reset, then req=01, op0=100 -> jk_preset_n low 1 cycle, ack=01 three cycles after request, err=0, q_in=1111.
REQ-033 Both requesters high from reset, op0=001 mask 0011, op1=010 mask 0011 -> requester 0 acked first, requester 1 next; final q_in=xx00, err=0 on both.
REQ-034 Q=0101, toggle mask 1111 -> jk_j=jk_k=1111 for 1 cycle, q_in=1010, ack with err=0.
REQ-035 op0=110 -> no J/K/preset/clear activity, ack=01 with err=1.
REQ-036 Bench forces q_in==qbar_in on bit 2 during set -> err=1 with ack.
REQ-037 Reset asserted in SETTLE -> next cycle IDLE, busy=0, no ack for the aborted command, all drives safe.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank sequencer: command codes, FSM states and the
// default bank width.
package jk_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_SET    = 3'b001,
        OP_RESET  = 3'b010,
        OP_TOGGLE = 3'b011,
        OP_PRESET = 3'b100,
        OP_CLEAR  = 3'b101,
        OP_BAD6   = 3'b110,
        OP_BAD7   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK
    } state_e;

endpackage

// File: rtl/jk_rr_arbiter.sv
// Two-requester round-robin arbiter with a one-hot combinational grant; the
// pointer hands priority to the other requester after every accepted grant.
module jk_rr_arbiter (
    input  logic       input_clock1_c_1,
    input  logic       input_reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (ptr) begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end else begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
    end

    // Granting requester 0 points at requester 1 next, and vice versa.
    always_ff @(posedge input_clock1_c_1) begin
        if (!input_reset_n) begin
            ptr <= 1'b0;
        end else if (take && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Sequences one command at a time onto a bank of JK flip-flops: drive for one
// cycle, wait for the bank to settle, then verify the read-back and ack.
module jk_bank_sequencer
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             input_clock1_c_1,
    input  logic             input_reset_n,
    input  logic [1:0]       req,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] mask0,
    input  logic [WIDTH-1:0] mask1,
    output logic [1:0]       ack,
    output logic             err,
    output logic             busy,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             jk_preset_n,
    output logic             jk_clear_n,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] qbar_in
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e           state, state_nxt;
    logic [3:0]       cnt;
    op_e              op_q;
    logic [WIDTH-1:0] mask_q, snap_q;
    logic [1:0]       gnt, gnt_q;
    logic             take;

    assign take = (state == ST_IDLE);

    jk_rr_arbiter u_arb (
        .input_clock1_c_1 (input_clock1_c_1),
        .input_reset_n    (input_reset_n),
        .req              (req),
        .take             (take),
        .gnt              (gnt)
    );

    // Read-back is bad if either rail disagrees with itself or the masked
    // bits do not show the effect the command should have had.
    function automatic logic check_fail(input op_e op, input logic [WIDTH-1:0] mask,
                                        input logic [WIDTH-1:0] snap,
                                        input logic [WIDTH-1:0] q,
                                        input logic [WIDTH-1:0] qb);
        logic bad;
        bad = |(q ~^ qb);
        case (op)
            OP_HOLD:   bad = bad | (|((q ^ snap) & mask));
            OP_SET:    bad = bad | (|(~q & mask));
            OP_RESET:  bad = bad | (|(q & mask));
            OP_TOGGLE: bad = bad | (|((q ^ ~snap) & mask));
            OP_PRESET: bad = bad | ~(&q);
            OP_CLEAR:  bad = bad | (|q);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    always_ff @(posedge input_clock1_c_1) begin
        if (!input_reset_n) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req != 2'b00) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == 4'd0) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Command latch and settle counter; the snapshot is the pre-drive Q.
    always_ff @(posedge input_clock1_c_1) begin
        if (!input_reset_n) begin
            cnt    <= 4'd0;
            op_q   <= OP_HOLD;
            mask_q <= '0;
            snap_q <= '0;
            gnt_q  <= 2'b00;
        end else if (state == ST_IDLE && req != 2'b00) begin
            cnt    <= SETTLE_LOAD;
            op_q   <= gnt[1] ? op_e'(op1) : op_e'(op0);
            mask_q <= gnt[1] ? mask1 : mask0;
            snap_q <= q_in;
            gnt_q  <= gnt;
        end else if (state == ST_SETTLE && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        ack         = 2'b00;
        err         = 1'b0;
        busy        = (state != ST_IDLE);
        jk_j        = '0;
        jk_k        = '0;
        jk_preset_n = 1'b1;
        jk_clear_n  = 1'b1;
        case (state)
            ST_DRIVE: begin
                case (op_q)
                    OP_SET:    jk_j = mask_q;
                    OP_RESET:  jk_k = mask_q;
                    OP_TOGGLE: begin
                        jk_j = mask_q;
                        jk_k = mask_q;
                    end
                    OP_PRESET: jk_preset_n = 1'b0;
                    OP_CLEAR:  jk_clear_n  = 1'b0;
                    default:   ;
                endcase
            end
            ST_CHECK: begin
                ack = gnt_q;
                err = check_fail(op_q, mask_q, snap_q, q_in, qbar_in);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a behavioural JK bank closes the loop, and a
// scoreboard of expected ack/err/final-Q entries is popped on every ack.
module tb_jk_bank_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req;
    logic [2:0]   op0, op1;
    logic [W-1:0] mask0, mask1;
    logic [1:0]   ack;
    logic         err, busy;
    logic [W-1:0] jk_j, jk_k;
    logic         jk_preset_n, jk_clear_n;
    logic [W-1:0] q_in, qbar_in;

    logic [W-1:0] bank_q;
    logic         load_en;
    logic [W-1:0] load_val;
    logic         fault;

    always #5 clk = ~clk;

    jk_bank_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
        .input_clock1_c_1 (clk),
        .input_reset_n    (rst_n),
        .req              (req),
        .op0              (op0),
        .op1              (op1),
        .mask0            (mask0),
        .mask1            (mask1),
        .ack              (ack),
        .err              (err),
        .busy             (busy),
        .jk_j             (jk_j),
        .jk_k             (jk_k),
        .jk_preset_n      (jk_preset_n),
        .jk_clear_n       (jk_clear_n),
        .q_in             (q_in),
        .qbar_in          (qbar_in)
    );

    // Behavioural bank: async-style preset/clear sampled on the clock, JK otherwise.
    always @(posedge clk) begin
        if (load_en)           bank_q <= load_val;
        else if (!jk_preset_n) bank_q <= '1;
        else if (!jk_clear_n)  bank_q <= '0;
        else                   bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
    end

    assign q_in    = bank_q;
    assign qbar_in = ~bank_q ^ (fault ? 4'b0100 : 4'b0000);

    typedef struct {
        logic [1:0]   ack;
        logic         err;
        logic [W-1:0] fin;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] mask;
        logic [W-1:0] init;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic         pre_n;
        logic         clr_n;
        logic         err;
        logic [W-1:0] fin;
    } vec_t;
    vec_t vecs[10];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load_bank(input logic [W-1:0] v);
        @(negedge clk);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic drive_req(input int r, input logic [2:0] op, input logic [W-1:0] mask);
        if (r == 0) begin
            op0 = op; mask0 = mask; req[0] = 1'b1;
        end else begin
            op1 = op; mask1 = mask; req[1] = 1'b1;
        end
    endtask

    // Waits (bounded) for the next ack, recording the first cycle's drive.
    task automatic collect(output int lat, output logic [W-1:0] j1, output logic [W-1:0] k1,
                           output logic p1, output logic c1, output logic b1, output int act);
        sb_t e;
        lat = -1; act = 0;
        j1 = '0; k1 = '0; p1 = 1'b1; c1 = 1'b1; b1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                j1 = jk_j; k1 = jk_k; p1 = jk_preset_n; c1 = jk_clear_n; b1 = busy;
            end
            if (jk_j != '0 || jk_k != '0 || !jk_preset_n || !jk_clear_n) act++;
            if (ack != 2'b00) begin
                lat = c;
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", {30'd0, ack}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack", {30'd0, ack}, {30'd0, e.ack});
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    chk("final_q", {28'd0, q_in}, {28'd0, e.fin});
                end
                req = req & ~ack;
                break;
            end
        end
        if (lat < 0) chk("ack_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int           lat, act, exp_act;
        logic [W-1:0] j1, k1;
        logic         p1, c1, b1;
        logic         saw_ack;

        vecs[0] = '{3'b100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111};
        vecs[1] = '{3'b101, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[2] = '{3'b011, 4'b1111, 4'b0101, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b1010};
        vecs[3] = '{3'b001, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0110};
        vecs[4] = '{3'b010, 4'b1001, 4'b1111, 4'b0000, 4'b1001, 1'b1, 1'b1, 1'b0, 4'b0110};
        vecs[5] = '{3'b000, 4'b1111, 4'b1100, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1100};
        vecs[6] = '{3'b110, 4'b1111, 4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0011};
        vecs[7] = '{3'b111, 4'b0101, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1000};
        vecs[8] = '{3'b001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0101};
        vecs[9] = '{3'b011, 4'b0011, 4'b1001, 4'b0011, 4'b0011, 1'b1, 1'b1, 1'b0, 4'b1010};

        rst_n = 1'b0; req = 2'b00; op0 = 3'b000; op1 = 3'b000;
        mask0 = '0; mask1 = '0; load_en = 1'b0; load_val = '0; fault = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_jk", {24'd0, jk_j, jk_k}, 32'd0);
        chk("rst_pre_clr", {30'd0, jk_preset_n, jk_clear_n}, 32'd3);

        // Simultaneous requests straight after reset: requester 0 first.
        @(negedge clk);
        rst_n = 1'b1;
        load_bank(4'b1100);
        drive_req(0, 3'b001, 4'b0011);
        drive_req(1, 3'b010, 4'b0011);
        sb_q.push_back('{2'b01, 1'b0, 4'b1111});
        sb_q.push_back('{2'b10, 1'b0, 4'b1100});
        collect(lat, j1, k1, p1, c1, b1, act);
        chk("rr_first_latency", lat, 32'd3);
        chk("rr_first_drive_j", {28'd0, j1}, 32'h3);
        collect(lat, j1, k1, p1, c1, b1, act);
        chk("rr_second_latency", lat, 32'd4);
        chk("rr_req_cleared", {30'd0, req}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            load_bank(vecs[i].init);
            drive_req(i % 2, vecs[i].op, vecs[i].mask);
            sb_q.push_back('{(i % 2 == 0) ? 2'b01 : 2'b10, vecs[i].err, vecs[i].fin});
            collect(lat, j1, k1, p1, c1, b1, act);
            exp_act = (vecs[i].j != '0 || vecs[i].k != '0 || !vecs[i].pre_n || !vecs[i].clr_n) ? 1 : 0;
            chk($sformatf("v%0d_latency", i), lat, 32'd3);
            chk($sformatf("v%0d_busy", i), {31'd0, b1}, 32'd1);
            chk($sformatf("v%0d_jk", i), {24'd0, j1, k1}, {24'd0, vecs[i].j, vecs[i].k});
            chk($sformatf("v%0d_pre_clr", i), {30'd0, p1, c1}, {30'd0, vecs[i].pre_n, vecs[i].clr_n});
            chk($sformatf("v%0d_drive_cycles", i), act, exp_act);
        end

        // Q equals Qbar on bit 2 during a set.
        load_bank(4'b0000);
        fault = 1'b1;
        drive_req(0, 3'b001, 4'b0011);
        sb_q.push_back('{2'b01, 1'b1, 4'b0011});
        collect(lat, j1, k1, p1, c1, b1, act);
        chk("fault_latency", lat, 32'd3);
        fault = 1'b0;

        // Reset while settling aborts the toggle.
        load_bank(4'b0000);
        drive_req(0, 3'b011, 4'b1111);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_settle", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ack_err", {29'd0, ack, err}, 32'd0);
        chk("abort_drive", {22'd0, jk_j, jk_k, jk_preset_n, jk_clear_n}, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        req = 2'b00;
        saw_ack = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack != 2'b00 || err || jk_j != '0 || jk_k != '0) saw_ack = 1'b1;
        end
        chk("abort_no_ack", {31'd0, saw_ack}, 32'd0);
        chk("abort_bank_q", {28'd0, q_in}, 32'hF);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
